// File: rtl/div_pkg.sv
// div_pkg: shared widths, state encoding, handshake constants and operand helper for div.
// Macro: DIV_EARLY_TERM_EN is consumed by div, not by this package.
package div_pkg;

    localparam int          REG_BUS          = 32;
    localparam int          DOUBLE_REG_BUS   = 64;
    localparam logic        RST_ENABLE       = 1'b1;
    localparam logic [31:0] ZERO_WORD        = 32'h0;
    localparam logic        DIV_RESULT_READY = 1'b1;
    localparam logic        DIV_RESULT_NOT_READY = 1'b0;
    localparam logic        DIV_START        = 1'b1;
    localparam logic        DIV_STOP         = 1'b0;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // Magnitude of an operand; 0x80000000 maps to itself, which is 2^31 read unsigned.
    function automatic logic [REG_BUS-1:0] magnitude(input logic sgn, input logic [REG_BUS-1:0] x);
        return (sgn && x[REG_BUS-1]) ? -x : x;
    endfunction

endpackage

// File: rtl/div.sv
// div: multi-cycle 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk           clock
//   rst_n         synchronous reset, active-high (RST_ENABLE)
//   signed_div_i  1 = signed divide, 0 = unsigned
//   opdata1_i     dividend, sampled only on the start cycle
//   opdata2_i     divisor, sampled only on the start cycle
//   start_i       request, held until the result is consumed
//   annul_i       abort an operation in progress
//   result_o      {remainder, quotient}, registered
//   ready_o       result_o valid, registered
// Macro: DIV_EARLY_TERM_EN skips iteration when |dividend| < |divisor|.
module div
    import div_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      signed_div_i,
    input  logic [REG_BUS-1:0]        opdata1_i,
    input  logic [REG_BUS-1:0]        opdata2_i,
    input  logic                      start_i,
    input  logic                      annul_i,
    output logic [DOUBLE_REG_BUS-1:0] result_o,
    output logic                      ready_o
);

    div_state_e         state, state_nxt;
    logic [5:0]         cnt;
    logic [64:0]        work;
    logic [REG_BUS-1:0] divisor;
    logic               neg_q, neg_r;
    logic [REG_BUS-1:0] mag1, mag2, quo, rem;
    logic [32:0]        trial;
    logic               go, early;

    assign mag1 = magnitude(signed_div_i, opdata1_i);
    assign mag2 = magnitude(signed_div_i, opdata2_i);
    assign go   = start_i == DIV_START && !annul_i;

`ifdef DIV_EARLY_TERM_EN
    assign early = mag1 < mag2;
`else
    assign early = 1'b0;
`endif

    // work holds the partial remainder in [63:32] (pre-shifted one bit) and
    // the dividend/quotient in [31:0]; the final remainder ends up in [64:33].
    assign trial = {1'b0, work[63:32]} - {1'b0, divisor};
    assign quo   = neg_q ? -work[31:0] : work[31:0];
    assign rem   = neg_r ? -work[64:33] : work[64:33];

    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE)
            state <= DIV_FREE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_FREE:    if (go) state_nxt = (opdata2_i == ZERO_WORD) ? DIV_BY_ZERO : early ? DIV_END : DIV_ON;
            DIV_BY_ZERO: state_nxt = DIV_END;
            DIV_ON:      state_nxt = annul_i ? DIV_FREE : (cnt == 6'd32) ? DIV_END : DIV_ON;
            DIV_END:     if (start_i == DIV_STOP) state_nxt = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n == RST_ENABLE) begin
            cnt      <= '0;
            work     <= '0;
            divisor  <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DIV_RESULT_NOT_READY;
        end else begin
            case (state)
                DIV_FREE: begin
                    ready_o  <= DIV_RESULT_NOT_READY;
                    result_o <= (go && early) ? {opdata1_i, ZERO_WORD} : '0;
                    if (go) begin
                        work    <= {ZERO_WORD, mag1, 1'b0};
                        divisor <= mag2;
                        neg_q   <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_r   <= signed_div_i & opdata1_i[31];
                        cnt     <= '0;
                    end
                end
                DIV_BY_ZERO: begin
                    ready_o  <= DIV_RESULT_READY;
                    result_o <= '0;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        cnt      <= '0;
                        work     <= '0;
                        result_o <= '0;
                    end else if (cnt != 6'd32) begin
                        work <= trial[32] ? {work[63:0], 1'b0} : {trial[31:0], work[31:0], 1'b1};
                        cnt  <= cnt + 6'd1;
                    end else begin
                        result_o <= {rem, quo};
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    // Early-terminated operations arrive here with ready_o still low.
                    ready_o <= (start_i == DIV_STOP) ? DIV_RESULT_NOT_READY : DIV_RESULT_READY;
                    if (start_i == DIV_STOP) result_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        signed_div = 1'b0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [63:0] result;
    logic        ready;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    div dut (
        .clk(clk),
        .rst_n(rst_n),
        .signed_div_i(signed_div),
        .opdata1_i(op1),
        .opdata2_i(op2),
        .start_i(start),
        .annul_i(annul),
        .result_o(result),
        .ready_o(ready)
    );

    function automatic longint ext(input logic sgn, input logic [31:0] v);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 0) return 64'd0;
        x = ext(sgn, a);
        y = ext(sgn, b);
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    function automatic int exp_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint x, y;
        if (b == 0) return 2;
        x = ext(sgn, a);
        y = ext(sgn, b);
        x = x < 0 ? -x : x;
        y = y < 0 ? -y : y;
`ifdef DIV_EARLY_TERM_EN
        if (x < y) return 2;
`endif
        return 34;
    endfunction

    // One full handshake: start, count edges until ready (bounded), hold one
    // more cycle, then drop start and capture the outputs one edge later.
    // Operands are scrambled after the start cycle to show they are not re-read.
    task automatic run(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [63:0] res, output logic held,
                       output logic rel_rdy, output logic [63:0] rel_res);
        @(negedge clk);
        signed_div = sgn;
        op1 = a;
        op2 = b;
        start = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            op1 = $urandom;
            op2 = $urandom;
        end while (ready !== 1'b1 && lat < 100);
        res = result;
        @(posedge clk);
        #1 held = (ready === 1'b1) && (result === res);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        rel_rdy = ready;
        rel_res = result;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset: ready=%b result=%h, want ready=0 result=0", ready, result);
        end
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_unsigned();
        int lat;
        logic [63:0] res, rel_res;
        logic held, rel_rdy;
        run(1'b0, 32'd100, 32'd7, lat, res, held, rel_rdy, rel_res);
        checks++;
        if (res !== {32'h2, 32'hE}) begin
            errors++;
            $display("FAIL udiv_100_7: result=%h, want %h", res, {32'h2, 32'hE});
        end
        checks++;
        if (lat !== 34) begin
            errors++;
            $display("FAIL udiv_latency: ready at cycle %0d, want 34", lat);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL udiv_hold: ready/result not held while start high");
        end
        checks++;
        if (rel_rdy !== 1'b0 || rel_res !== 64'd0) begin
            errors++;
            $display("FAIL udiv_release: ready=%b result=%h, want 0 and 0", rel_rdy, rel_res);
        end
    endtask

    task automatic test_signed();
        logic        sg [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] a  [4] = '{32'hFFFFFF9C, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] b  [4] = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd2};
        logic [63:0] ex [4] = '{{32'hFFFFFFFE, 32'hFFFFFFF2}, {32'h0, 32'h80000000},
                                {32'h1, 32'h7FFFFFFF}, {32'hFFFFFFFF, 32'h0}};
        int lat;
        logic [63:0] res, rel_res;
        logic held, rel_rdy;
        for (int i = 0; i < 4; i++) begin
            run(sg[i], a[i], b[i], lat, res, held, rel_rdy, rel_res);
            checks++;
            if (res !== ex[i] || lat !== 34) begin
                errors++;
                $display("FAIL vector_%0d: result=%h lat=%0d, want %h lat=34", i, res, lat, ex[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        int lat;
        logic [63:0] res, rel_res;
        logic held, rel_rdy;
        run(1'b0, 32'h12345678, 32'd0, lat, res, held, rel_rdy, rel_res);
        checks++;
        if (res !== 64'd0 || lat !== 2) begin
            errors++;
            $display("FAIL div_zero: result=%h lat=%0d, want 0 lat=2", res, lat);
        end
    endtask

    task automatic test_annul_reset();
        logic ok;
        int lat;
        logic [63:0] res, rel_res;
        logic held, rel_rdy;
        @(negedge clk);
        signed_div = 1'b0;
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        repeat (10) @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 if (ready !== 1'b0 || result !== 64'd0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL annul: ready=%b result=%h after annul, want 0 and 0", ready, result);
        end
        @(negedge clk);
        op1 = 32'd1000;
        op2 = 32'd3;
        start = 1'b1;
        repeat (15) @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1 if (ready !== 1'b0 || result !== 64'd0) ok = 1'b0;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_reset: ready=%b result=%h after reset, want 0 and 0", ready, result);
        end
        run(1'b0, 32'd9, 32'd3, lat, res, held, rel_rdy, rel_res);
        checks++;
        if (res !== {32'd0, 32'd3} || lat !== 34) begin
            errors++;
            $display("FAIL after_abort_9_3: result=%h lat=%0d, want %h lat=34", res, lat, {32'd0, 32'd3});
        end
    endtask

    task automatic test_early();
        int lat;
        logic [63:0] res, rel_res;
        logic held, rel_rdy;
        run(1'b0, 32'd5, 32'd9, lat, res, held, rel_rdy, rel_res);
        checks++;
        if (res !== {32'd5, 32'd0} || lat !== exp_lat(1'b0, 32'd5, 32'd9)) begin
            errors++;
            $display("FAIL early_5_9: result=%h lat=%0d, want %h lat=%0d",
                     res, lat, {32'd5, 32'd0}, exp_lat(1'b0, 32'd5, 32'd9));
        end
        checks++;
        if (!held || rel_rdy !== 1'b0 || rel_res !== 64'd0) begin
            errors++;
            $display("FAIL early_handshake: held=%b rel_ready=%b rel_result=%h, want 1 0 0", held, rel_rdy, rel_res);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [63:0] res, rel_res, want;
        logic held, rel_rdy, sg;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            sg = 1'($urandom);
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = $urandom_range(1, 255);
                2: b = (i % 8 == 2) ? 32'd0 : -$urandom_range(1, 255);
                default: b = a ^ 32'($urandom_range(0, 7));
            endcase
            want = model(sg, a, b);
            run(sg, a, b, lat, res, held, rel_rdy, rel_res);
            checks++;
            if (res !== want || lat !== exp_lat(sg, a, b) || !held || rel_rdy !== 1'b0 || rel_res !== 64'd0) begin
                errors++;
                $display("FAIL random_%0d: s=%b %h/%h result=%h lat=%0d held=%b rel=%b/%h, want %h lat=%0d",
                         i, sg, a, b, res, lat, held, rel_rdy, rel_res, want, exp_lat(sg, a, b));
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul_reset();
        test_early();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
